// File: rtl/mux_tx_pkg.sv
// Shared types and constants for the mux-driven serial transmitter.
package mux_tx_pkg;

    localparam int DATA_BITS = 8;
    localparam int SEL_W     = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Cycles from the first START cycle to the last STOP cycle.
    function automatic int frame_len(input int clks_per_bit, input bit parity_en);
        return (10 + (parity_en ? 1 : 0)) * clks_per_bit;
    endfunction

    function automatic int baud_cnt_width(input int clks_per_bit);
        return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
    endfunction

endpackage

// File: rtl/mux_tx_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, wraps on terminal count or clear.
module mux_tx_baud_cnt
    import mux_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int CNT_W        = baud_cnt_width(CLKS_PER_BIT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    output logic             tc_o,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc_o  = (cnt_q == LAST);
    assign cnt_o = cnt_q;

    // Next count: restart on clear or at the end of a bit period.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || tc_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mux_serial_tx.sv
// Byte-serial transmitter that walks an external 8:1 mux select and frames its
// output as an LSB-first async line: start, 8 data, optional even parity, stop.
module mux_serial_tx
    import mux_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] din,
    input  logic                 din_valid,
    output logic                 din_ready,
    output logic [DATA_BITS-1:0] mux_a,
    output logic [SEL_W-1:0]     mux_s,
    input  logic                 mux_y,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam int CNT_W = baud_cnt_width(CLKS_PER_BIT);
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(DATA_BITS - 1);

    tx_state_e            state_q, state_d;
    logic [DATA_BITS-1:0] mux_a_q, mux_a_d;
    logic [SEL_W-1:0]     mux_s_q, mux_s_d;
    logic                 busy_q, busy_d;
    logic                 tc_s;
    logic                 cnt_clr_s;
    logic                 tx_s;
    logic [CNT_W-1:0]     cnt_s;

    // Holding the counter cleared in IDLE guarantees START begins at count 0.
    assign cnt_clr_s = (state_q == ST_IDLE);

    mux_tx_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_baud_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (cnt_clr_s),
        .tc_o  (tc_s),
        .cnt_o (cnt_s)
    );

    // Next-state, held-byte and select sequencing.
    always_comb begin
        state_d = state_q;
        mux_a_d = mux_a_q;
        mux_s_d = mux_s_q;
        busy_d  = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (din_valid) begin
                    state_d = ST_START;
                    mux_a_d = din;
                    mux_s_d = 3'd0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (tc_s) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (tc_s) begin
                    if (mux_s_q == LAST_SEL) begin
                        state_d = PARITY_EN ? ST_PARITY : ST_STOP;
                    end else begin
                        mux_s_d = mux_s_q + 3'd1;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (tc_s) begin
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (tc_s) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    mux_s_d = 3'd0;
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                mux_s_d = 3'd0;
            end
        endcase
    end

    // Line level is a pure decode of registered state, so reset forces idle-high at once.
    always_comb begin
        tx_s = 1'b1;
        case (state_q)
            ST_IDLE:   tx_s = 1'b1;
            ST_START:  tx_s = 1'b0;
            ST_DATA:   tx_s = mux_y;
            ST_PARITY: tx_s = ^mux_a_q;
            ST_STOP:   tx_s = 1'b1;
            default:   tx_s = 1'b1;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mux_a_q <= 8'h00;
            mux_s_q <= 3'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mux_a_q <= mux_a_d;
            mux_s_q <= mux_s_d;
            busy_q  <= busy_d;
        end
    end

    assign din_ready = (state_q == ST_IDLE);
    assign busy      = busy_q;
    assign done      = (state_q == ST_STOP) && tc_s;
    assign mux_a     = mux_a_q;
    assign mux_s     = mux_s_q;
    assign tx        = tx_s;

endmodule

// File: tb/tb_mux_serial_tx.sv
// Bench for mux_serial_tx: three configurations checked against a bit-slot frame model.
module tb_mux_serial_tx;

    logic       clk;
    logic       rst_n;
    logic [7:0] din_r [3];
    logic       dv_r  [3];
    logic       rdy_w [3];
    logic [7:0] a_w   [3];
    logic [2:0] s_w   [3];
    logic       y_w   [3];
    logic       tx_w  [3];
    logic       busy_w[3];
    logic       done_w[3];

    int vectors;
    int miscompares;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 8:1 mux between each transmitter's A/S and its Y input.
    assign y_w[0] = a_w[0][s_w[0]];
    assign y_w[1] = a_w[1][s_w[1]];
    assign y_w[2] = a_w[2][s_w[2]];

    mux_serial_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .din(din_r[0]), .din_valid(dv_r[0]),
        .din_ready(rdy_w[0]), .mux_a(a_w[0]), .mux_s(s_w[0]), .mux_y(y_w[0]),
        .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]));

    mux_serial_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .din(din_r[1]), .din_valid(dv_r[1]),
        .din_ready(rdy_w[1]), .mux_a(a_w[1]), .mux_s(s_w[1]), .mux_y(y_w[1]),
        .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]));

    mux_serial_tx #(.CLKS_PER_BIT(1), .PARITY_EN(1'b0)) dut2 (
        .clk(clk), .rst_n(rst_n), .din(din_r[2]), .din_valid(dv_r[2]),
        .din_ready(rdy_w[2]), .mux_a(a_w[2]), .mux_s(s_w[2]), .mux_y(y_w[2]),
        .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]));

    function automatic int cpb_of(input int k);
        return (k == 2) ? 1 : 4;
    endfunction

    function automatic bit par_of(input int k);
        return (k == 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input int k, input logic [7:0] held);
        chk($sformatf("idle_tx%0d", k),    32'(tx_w[k]),   32'd1);
        chk($sformatf("idle_rdy%0d", k),   32'(rdy_w[k]),  32'd1);
        chk($sformatf("idle_busy%0d", k),  32'(busy_w[k]), 32'd0);
        chk($sformatf("idle_done%0d", k),  32'(done_w[k]), 32'd0);
        chk($sformatf("idle_sel%0d", k),   32'(s_w[k]),    32'd0);
        chk($sformatf("idle_a%0d", k),     32'(a_w[k]),    32'(held));
    endtask

    // Expected line level for bit slot 'slot' of a frame carrying b.
    function automatic logic slot_bit(input logic [7:0] b, input int slot, input bit par);
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot-1];
        if (par && slot == 9) return logic'($countones(b) % 2);
        return 1'b1;
    endfunction

    // Expected select: bit index during data, 7 afterwards until the frame ends.
    function automatic int slot_sel(input int slot);
        if (slot == 0) return 0;
        if (slot <= 8) return slot - 1;
        return 7;
    endfunction

    // Offers b from an idle negedge, then checks every cycle of the frame.
    task automatic run_frame(input int k, input logic [7:0] b, input bit keep_valid,
                             input logic [7:0] next_b, input int inject_cyc);
        int n;
        bit par;
        int len;
        int slot;
        n   = cpb_of(k);
        par = par_of(k);
        len = (10 + (par ? 1 : 0)) * n;
        din_r[k] = b;
        dv_r[k]  = 1'b1;
        chk($sformatf("pre_rdy%0d", k), 32'(rdy_w[k]), 32'd1);
        chk($sformatf("pre_tx%0d", k),  32'(tx_w[k]),  32'd1);
        @(posedge clk);
        @(negedge clk);
        if (keep_valid) begin
            din_r[k] = next_b;
        end else begin
            dv_r[k] = 1'b0;
        end
        for (int c = 1; c <= len; c++) begin
            slot = (c - 1) / n;
            chk($sformatf("tx%0d_c%0d", k, c),   32'(tx_w[k]),   32'(slot_bit(b, slot, par)));
            chk($sformatf("sel%0d_c%0d", k, c),  32'(s_w[k]),    32'(slot_sel(slot)));
            chk($sformatf("busy%0d_c%0d", k, c), 32'(busy_w[k]), 32'd1);
            chk($sformatf("rdy%0d_c%0d", k, c),  32'(rdy_w[k]),  32'd0);
            chk($sformatf("done%0d_c%0d", k, c), 32'(done_w[k]), 32'(c == len));
            chk($sformatf("a%0d_c%0d", k, c),    32'(a_w[k]),    32'(b));
            if (c == inject_cyc) begin
                din_r[k] = 8'hFF;
                dv_r[k]  = 1'b1;
            end else if (c == inject_cyc + 1) begin
                din_r[k] = b;
                dv_r[k]  = 1'b0;
            end
            @(negedge clk);
        end
        chk_idle(k, b);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] rb;
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        for (int k = 0; k < 3; k++) begin
            din_r[k] = 8'h00;
            dv_r[k]  = 1'b0;
        end

        // Reset held with random inputs.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                din_r[k] = 8'($urandom);
                dv_r[k]  = 1'($urandom);
            end
        end
        for (int k = 0; k < 3; k++) begin
            chk_idle(k, 8'h00);
            dv_r[k] = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed and random frames without parity.
        run_frame(0, 8'hA5, 1'b0, 8'h00, -1);
        for (int i = 0; i < 2; i++) begin
            rb = 8'($urandom);
            run_frame(0, rb, 1'b0, 8'h00, -1);
        end

        // Parity frames.
        run_frame(1, 8'h07, 1'b0, 8'h00, -1);
        for (int i = 0; i < 2; i++) begin
            rb = 8'($urandom);
            run_frame(1, rb, 1'b0, 8'h00, -1);
        end

        // Byte offered mid-frame is ignored.
        run_frame(0, 8'h3C, 1'b0, 8'h00, 10);

        // Asynchronous reset while on data bit 3.
        rb = 8'($urandom);
        din_r[0] = rb;
        dv_r[0]  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dv_r[0] = 1'b0;
        for (int c = 1; c < 18; c++) @(negedge clk);
        chk("midreset_sel_before", 32'(s_w[0]), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle(0, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_frame(0, 8'h81, 1'b0, 8'h00, -1);

        // One cycle per bit, back-to-back with valid held high.
        run_frame(2, 8'h00, 1'b1, 8'hFF, -1);
        run_frame(2, 8'hFF, 1'b0, 8'h00, -1);
        for (int i = 0; i < 2; i++) begin
            rb = 8'($urandom);
            run_frame(2, rb, 1'b0, 8'h00, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mux_serial_tx.md
Name: mux_serial_tx

Overview:
Byte-serial transmitter that drives the select and data inputs of the team's 8:1 gate-level multiplexer and reads back its single-bit output. It accepts a byte over a valid/ready handshake and holds it on the mux data bus. It steps the mux select 0..7 and frames the selected bits as an LSB-first async serial line: start, 8 data, optional even parity, stop. It sits directly upstream of the mux and drives its A and S.

Parameters:
CLKS_PER_BIT, 4, clock cycles per serial bit period; legal range >=1.
PARITY_EN, 0, 1 inserts an even-parity bit between data bit 7 and stop.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
din  in  8  byte to transmit.
din_valid  in  1  din is valid.
din_ready  out  1  block can accept a byte; high only in IDLE.
mux_a  out  8  held byte; drives mux data inputs A[7:0].
mux_s  out  3  current bit index; drives mux select S[2:0].
mux_y  in  1  mux output Y, combinational from mux_a/mux_s.
tx  out  1  serial line; idle high.
busy  out  1  high from accept until return to IDLE.
done  out  1  one-cycle pulse on the last cycle of STOP.

Behaviour:
- Reset (async assert, sync deassert by the clk domain) sets: state IDLE, tx=1, din_ready=1, busy=0, done=0, mux_a=8'h00, mux_s=0, baud counter=0. Reset mid-frame aborts the frame immediately; no partial stop bit.
- States: IDLE, START, DATA, PARITY, STOP. PARITY is reachable only when PARITY_EN=1.
- IDLE: tx=1 and din_ready=1. A transfer is accepted on the edge where din_valid && din_ready. On that edge: mux_a<=din, mux_s<=0, baud counter<=0, state<=START, busy<=1.
- Each of START, DATA (per bit), PARITY and STOP lasts exactly CLKS_PER_BIT cycles. The baud counter runs 0..CLKS_PER_BIT-1. The terminal count ends the bit and clears the counter.
- tx is decoded from registered state: START=0, DATA=mux_y, PARITY=^mux_a (even parity), STOP/IDLE=1. mux_y is stable all cycle because mux_a and mux_s are registered.
- START terminal count -> DATA, with mux_s=0.
- DATA terminal count with mux_s<7 -> mux_s<=mux_s+1.
- DATA terminal count with mux_s==7 -> PARITY if PARITY_EN, else STOP. mux_s holds at 7 and does not wrap.
- STOP terminal count: done=1 for that cycle, then state<=IDLE, busy<=0, mux_s<=0.
- mux_a is unchanged from accept until the next accept, including while in IDLE.
- Frame length is (10+PARITY_EN)*CLKS_PER_BIT cycles from the first START cycle to the last STOP cycle. First START cycle is the cycle after accept.
- din_ready=0 while busy. din_valid in that window is ignored, and the source must hold it.
- Minimum gap between frames is one IDLE cycle.
- din_valid asserted in the same cycle that STOP ends is not accepted; it is accepted on the following IDLE cycle.
- CLKS_PER_BIT=1: one cycle per bit; all transitions still hold.
- Baud counter width: $clog2(CLKS_PER_BIT), minimum 1 bit.

Decomposition:
- Shared package mux_tx_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - DATA_BITS=8 and SEL_W=3 constants;
  - function returning frame length for given CLKS_PER_BIT/PARITY_EN.
- One sub-module, mux_tx_baud_cnt: parameterised counter with a clear input and a terminal-count output.

Test Plan:
- Setup for all scenarios: bench instantiates the block with the team's 8:1 gate-level mux on mux_a/mux_s/mux_y.
- Reset: hold rst_n=0 with random din/din_valid -> tx=1, din_ready=1, busy=0, done=0, mux_a=0x00, mux_s=0.
- CLKS_PER_BIT=4, send 0xA5:
  - tx is 0 for 4 cycles, then 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for 4 cycles;
  - mux_s steps 0..7;
  - done pulses once on cycle 40 after accept;
  - busy is high for 40 cycles.
- PARITY_EN=1, send 0x07: three ones, so parity bit=1. Frame is 11 bits (44 cycles at CLKS_PER_BIT=4) with tx=1 in bit slot 9.
- Send 0x3C, then pulse din_valid with 0xFF mid-frame -> 0xFF not accepted, din_ready stays 0, and the frame carries 0x3C bits unchanged.
- Reset mid-DATA (mux_s=3): drop rst_n asynchronously -> tx=1 that same cycle and state IDLE. A new byte 0x81 after release transmits a complete frame.
- CLKS_PER_BIT=1, back-to-back 0x00 and 0xFF with din_valid held high -> frames of 10 cycles each, separated by exactly 1 IDLE cycle, data bits all 0 then all 1.
